dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequencing controller and 2-way arbiter placed in front of a byte-wide, single-port, synchronous-read data memory (256 x 8).
- Requester 0 is the CPU load/store path; requester 1 is the loader/debug path.
- Each 16-bit big-endian access is split into two byte cycles: high byte at A, low byte at A+1.
- Responds to the winning requester with a one-cycle ack, plus read data or an error flag.

Parameters:
- MEM_AW, 8, memory byte-address width; bits [15:MEM_AW] of a request address must be zero.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; level, held with its fields stable until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  16  port 0 byte address (ALU result).
- p0_wdata  in  16  port 0 write data (register file).
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_err  out  1  port 0 address-range error; valid only with p0_ack.
- p0_rdata  out  16  port 0 read data; valid with p0_ack on reads.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory byte access enable.
- mem_we  out  1  memory byte write enable.
- mem_addr  out  MEM_AW  memory byte address.
- mem_wdata  out  8  memory byte write data.
- mem_rdata  in  8  memory read byte, valid the cycle after mem_en with mem_we=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, HI, LO, FIN, ACK. Moore outputs.
- IDLE:
  - Evaluate p0_req/p1_req; choose a winner; latch its we/addr/wdata and port index.
  - Out-of-range address (addr[15:MEM_AW] != 0) -> ACK with err=1; no memory cycle is issued.
  - Otherwise -> HI.
  - No request -> stay in IDLE.
- HI: mem_en=1, mem_addr=A, mem_we=we, mem_wdata=wdata[15:8]. -> LO.
- LO: mem_en=1, mem_addr=(A+1) mod 2^MEM_AW, mem_wdata=wdata[7:0].
  - Read: capture mem_rdata into rdata[15:8], -> FIN.
  - Write: -> ACK.
- FIN: mem_en=0; capture mem_rdata into rdata[7:0]. -> ACK.
- ACK: winner's ack=1; err as latched. -> IDLE unconditionally.
  - The requester must drop req in the ack cycle; it may re-raise req in the next IDLE cycle.
- Latency, counted from the IDLE sampling edge:
  - Read: ack high in the 4th cycle after.
  - Write: ack high in the 3rd cycle after.
  - Error: ack high in the 1st cycle after.
  - Back-to-back throughput: one transaction per 5 cycles (read) or 4 cycles (write).
- Arbitration:
  - Only one request is in service at a time; requests are never dropped.
  - Simultaneous req with RR_EN=1: the port not served last wins. Last-served pointer resets to 1, so port 0 wins the first tie.
  - RR_EN=0: port 0 always wins a tie.
  - The losing port waits; its req stays high.
- Read data register:
  - Shared between ports; p0_rdata = p1_rdata = that register.
  - Holds its value until the next read capture.
  - Resets to 0 and is not cleared on writes or errors.
- mem_we is 0 whenever mem_en is 0.
- mem_addr and mem_wdata are 0 outside HI/LO.
- Address A=0xFF (MEM_AW=8): low byte goes to 0x00 (wrap), no error.
- Reset:
  - All outputs 0 immediately; state=IDLE; rdata=0; pointer=1.
  - Reset during a write after HI leaves a partial write (high byte only). No rollback; software re-issues the write.
- A requester changing fields while req is high, before ack, is illegal; the controller uses the values latched in IDLE.

Decomposition:
- Shared package dmem_pkg:
  - State enum (IDLE, HI, LO, FIN, ACK).
  - Default MEM_AW.
  - Port index constants PORT_CPU=0, PORT_DBG=1.
- Sub-module dmem_rr_arb: combinational 2-way picker, taking the req pair, the last-served pointer and RR_EN, and returning a grant index plus a valid flag. The pointer register lives in the parent and updates on the IDLE->HI/ACK transition.

Test Plan:
- Write then read: p0 write A=0x10, wdata=0xBEEF.
  - mem byte writes 0x10<-0xBE (HI), 0x11<-0xEF (LO).
  - p0_ack in the 3rd cycle after sampling.
  - p0 read A=0x10 -> p0_rdata=0xBEEF with p0_ack in the 4th cycle; p0_err=0.
- Wrap: p1 write A=0x00FF, wdata=0x1234 -> bytes 0xFF<-0x12, 0x00<-0x34. Read back A=0x00FF -> 0x1234.
- Range error: p0 read A=0x0100.
  - p0_ack and p0_err=1 in the 1st cycle after sampling.
  - mem_en never asserted; p0_rdata unchanged.
- Tie with RR_EN=1: p0 and p1 held high continuously, both reads.
  - Service order p0, p1, p0, p1; each ack lands only on its own port.
  - RR_EN=0, same stimulus with p0 re-raising req -> p0 served every time while p1 waits.
- Reset mid-write: p0 write A=0x20, wdata=0xAAAA; assert rst during LO.
  - All outputs 0 in the same cycle; state=IDLE.
  - Memory 0x20=0xAA; 0x21 holds its prior value.
  - After release, the next request proceeds normally.
- Back-to-back: p0 issues 4 reads with req re-raised in the cycle after each ack.
  - Acks spaced exactly 5 cycles apart; busy low for exactly one cycle between transactions.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

  typedef enum logic [2:0] {IDLE, HI, LO, FIN, ACK} state_t;

  localparam int   MEM_AW_DEF = 8;
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DBG   = 1'b1;

endpackage

// File: rtl/dmem_access_ctrl_arb.sv
// Combinational 2-way picker; round-robin favours the port not served last.
module dmem_rr_arb
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    if (req == 2'b11) grant = rr_en ? ~last : PORT_CPU;
    else if (req[1])  grant = PORT_DBG;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates two 16-bit requesters onto a byte-wide synchronous-read memory,
// splitting each access into a big-endian high/low byte pair.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [15:0]       p0_addr,
  input  logic [15:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [15:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [15:0]       p1_addr,
  input  logic [15:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [15:0]       p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_t            state;
  logic              we_q, port_q, last_q;
  logic [MEM_AW-1:0] addr_q;
  logic [15:0]       wdata_q, rdata_q;

  logic              grant, grant_vld;
  logic              sel_we, sel_err;
  logic [15:0]       sel_addr, sel_wdata;

  dmem_rr_arb u_arb (
    .req   ({p1_req, p0_req}),
    .last  (last_q),
    .rr_en (RR_EN),
    .grant (grant),
    .valid (grant_vld)
  );

  always_comb begin
    sel_we    = (grant == PORT_DBG) ? p1_we    : p0_we;
    sel_addr  = (grant == PORT_DBG) ? p1_addr  : p0_addr;
    sel_wdata = (grant == PORT_DBG) ? p1_wdata : p0_wdata;
    sel_err   = (sel_addr >> MEM_AW) != 16'd0;
  end

  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      port_q    <= PORT_CPU;
      last_q    <= PORT_DBG;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (grant_vld) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr[MEM_AW-1:0];
            wdata_q <= sel_wdata;
            port_q  <= grant;
            last_q  <= grant;
            busy    <= 1'b1;
            if (sel_err) begin
              // Out-of-range: answer immediately, never touch the memory.
              state  <= ACK;
              p0_ack <= (grant == PORT_CPU);
              p1_ack <= (grant == PORT_DBG);
              p0_err <= (grant == PORT_CPU);
              p1_err <= (grant == PORT_DBG);
            end else begin
              state     <= HI;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[MEM_AW-1:0];
              mem_wdata <= sel_wdata[15:8];
            end
          end
        end
        HI: begin
          state     <= LO;
          mem_en    <= 1'b1;
          mem_we    <= we_q;
          mem_addr  <= addr_q + MEM_AW'(1);
          mem_wdata <= wdata_q[7:0];
        end
        LO: begin
          if (!we_q) begin
            rdata_q[15:8] <= mem_rdata;
            state         <= FIN;
          end else begin
            state  <= ACK;
            p0_ack <= (port_q == PORT_CPU);
            p1_ack <= (port_q == PORT_DBG);
          end
        end
        FIN: begin
          rdata_q[7:0] <= mem_rdata;
          state        <= ACK;
          p0_ack       <= (port_q == PORT_CPU);
          p1_ack       <= (port_q == PORT_DBG);
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with behavioural byte memories.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err, mem_en, mem_we, busy;
  logic [15:0] p0_rdata, p1_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic        fp_p0_req = 0, fp_p1_req = 0;
  logic [15:0] fp_p0_addr = 16'h0000, fp_p1_addr = 16'h0002;
  logic        fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err, fp_mem_en, fp_mem_we, fp_busy;
  logic [15:0] fp_p0_rdata, fp_p1_rdata;
  logic [7:0]  fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

  logic [7:0]  mem    [256];
  logic [7:0]  fp_mem [256];
  int          en_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_AW(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_access_ctrl #(.MEM_AW(8), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(fp_p0_req), .p0_we(1'b0), .p0_addr(fp_p0_addr), .p0_wdata(16'h0000),
    .p0_ack(fp_p0_ack), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
    .p1_req(fp_p1_req), .p1_we(1'b0), .p1_addr(fp_p1_addr), .p1_wdata(16'h0000),
    .p1_ack(fp_p1_ack), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    <= 8'h5A;
      fp_mem[i] <= 8'h5A;
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
    if (fp_mem_en) begin
      if (fp_mem_we) fp_mem[fp_mem_addr] <= fp_mem_wdata;
      else           fp_mem_rdata        <= fp_mem[fp_mem_addr];
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic do_req(input logic port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output logic err,
                        output logic [15:0] rd, output logic wrong_ack);
    lat = 0; wrong_ack = 0;
    if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1; end
    else      begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1; end
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (port ? p0_ack : p1_ack) wrong_ack = 1;
    end while (!(port ? p1_ack : p0_ack) && lat < 20);
    err = port ? p1_err : p0_err;
    rd  = port ? p1_rdata : p0_rdata;
    p0_req = 0; p1_req = 0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1;
    @(negedge clk);
    n_checks++; if ({busy, mem_en, mem_we, p0_ack, p1_ack, p0_err, p1_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000000", {busy, mem_en, mem_we, p0_ack, p1_ack, p0_err, p1_err}); end
    n_checks++; if ({mem_addr, mem_wdata, p0_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, p0_rdata}); end
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic err, wa; logic [15:0] rd;
    do_req(0, 1, 16'h0010, 16'hBEEF, lat, err, rd, wa);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if ({mem[8'h10], mem[8'h11]} !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_bytes: got %h expected beef", {mem[8'h10], mem[8'h11]}); end
    n_checks++; if (wa !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_ack_err: got %b%b expected 00", wa, err); end
    do_req(0, 0, 16'h0010, 16'h0000, lat, err, rd, wa);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected beef", rd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", err); end
  endtask

  task automatic test_wrap();
    int lat; logic err, wa; logic [15:0] rd;
    do_req(1, 1, 16'h00FF, 16'h1234, lat, err, rd, wa);
    n_checks++; if ({mem[8'hFF], mem[8'h00]} !== 16'h1234) begin
      n_fail++; $display("FAIL wrap_bytes: got %h expected 1234", {mem[8'hFF], mem[8'h00]}); end
    n_checks++; if (lat !== 3 || wa !== 1'b0) begin n_fail++; $display("FAIL wrap_wr_ack: got lat %0d other %b expected 3 0", lat, wa); end
    do_req(1, 0, 16'h00FF, 16'h0000, lat, err, rd, wa);
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL wrap_rd_data: got %h expected 1234", rd); end
  endtask

  task automatic test_range_err();
    int lat, en0; logic err, wa; logic [15:0] rd;
    en0 = en_cnt;
    do_req(0, 0, 16'h0100, 16'h0000, lat, err, rd, wa);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency: got %0d expected 1", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", err); end
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL err_rdata_hold: got %h expected 1234", rd); end
    n_checks++; if (en_cnt !== en0) begin n_fail++; $display("FAIL err_no_mem: got %0d expected %0d", en_cnt, en0); end
  endtask

  task automatic test_rr_tie();
    int got, cyc; logic [1:0] reraise; logic exp_port; logic [15:0] exp_rd;
    pulse_reset();
    got = 0; cyc = 0; reraise = 2'b00;
    p0_we = 0; p1_we = 0; p0_addr = 16'h0010; p1_addr = 16'h00FF;
    p0_req = 1; p1_req = 1;
    while (got < 4 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (reraise[0]) p0_req = 1;
      if (reraise[1]) p1_req = 1;
      reraise = 2'b00;
      if (p0_ack || p1_ack) begin
        exp_port = got[0];
        exp_rd   = exp_port ? 16'h1234 : 16'hBEEF;
        n_checks++; if ({p1_ack, p0_ack} !== (exp_port ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_order_%0d: got acks %b expected %b", got, {p1_ack, p0_ack}, exp_port ? 2'b10 : 2'b01); end
        n_checks++; if (p0_rdata !== exp_rd) begin
          n_fail++; $display("FAIL rr_data_%0d: got %h expected %h", got, p0_rdata, exp_rd); end
        if (p0_ack) begin p0_req = 0; reraise[0] = 1; end
        if (p1_ack) begin p1_req = 0; reraise[1] = 1; end
        got++;
      end
    end
    p0_req = 0; p1_req = 0;
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL rr_timeout: got %0d acks expected 4", got); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int got, cyc; logic p1_seen, reraise;
    got = 0; cyc = 0; p1_seen = 0; reraise = 0;
    fp_p0_req = 1; fp_p1_req = 1;
    while (got < 3 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (reraise) fp_p0_req = 1;
      reraise = 0;
      if (fp_p1_ack) p1_seen = 1;
      if (fp_p0_ack) begin
        n_checks++; if (fp_p0_err !== 1'b0 || fp_p0_rdata !== 16'h5A5A) begin
          n_fail++; $display("FAIL fp_p0_resp_%0d: got err %b data %h expected 0 5a5a", got, fp_p0_err, fp_p0_rdata); end
        fp_p0_req = 0; reraise = 1; got++;
      end
    end
    fp_p0_req = 0;
    n_checks++; if (got !== 3 || p1_seen !== 1'b0) begin
      n_fail++; $display("FAIL fp_p0_wins: got %0d p0 acks p1 %b expected 3 0", got, p1_seen); end
    cyc = 0;
    while (!fp_p1_ack && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++; if (fp_p1_ack !== 1'b1 || fp_p1_err !== 1'b0) begin
      n_fail++; $display("FAIL fp_p1_served: got ack %b err %b expected 1 0", fp_p1_ack, fp_p1_err); end
    fp_p1_req = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat; logic err, wa; logic [15:0] rd;
    p0_we = 1; p0_addr = 16'h0020; p0_wdata = 16'hAAAA; p0_req = 1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1;
    #1;
    n_checks++; if ({busy, mem_en, mem_we, p0_ack, mem_addr, mem_wdata, p0_rdata} !== 36'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h expected 0", {busy, mem_en, mem_we, p0_ack, mem_addr, mem_wdata, p0_rdata}); end
    p0_req = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_checks++; if ({mem[8'h20], mem[8'h21]} !== 16'hAA5A) begin
      n_fail++; $display("FAIL midrst_partial: got %h expected aa5a", {mem[8'h20], mem[8'h21]}); end
    do_req(0, 0, 16'h0020, 16'h0000, lat, err, rd, wa);
    n_checks++; if (lat !== 4 || rd !== 16'hAA5A) begin
      n_fail++; $display("FAIL midrst_recover: got lat %0d data %h expected 4 aa5a", lat, rd); end
  endtask

  task automatic test_back_to_back();
    int cyc, got, last_ack, low; logic reraise;
    cyc = 0; got = 0; last_ack = 0; low = 0; reraise = 0;
    p0_we = 0; p0_addr = 16'h0010; p0_req = 1;
    while (got < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (reraise) p0_req = 1;
      reraise = 0;
      if (got > 0 && !busy) low++;
      if (p0_ack) begin
        if (got > 0) begin
          n_checks++; if (cyc - last_ack !== 5 || low !== 1) begin
            n_fail++; $display("FAIL b2b_gap_%0d: got spacing %0d idle %0d expected 5 1", got, cyc - last_ack, low); end
        end
        n_checks++; if (p0_rdata !== 16'hBEEF) begin
          n_fail++; $display("FAIL b2b_data_%0d: got %h expected beef", got, p0_rdata); end
        last_ack = cyc; low = 0; p0_req = 0; got++;
        reraise = (got < 4);
      end
    end
    p0_req = 0;
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b_timeout: got %0d acks expected 4", got); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_range_err();
    test_rr_tie();
    test_fixed_prio();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
